// File: rtl/z80_bus_responder.sv
// Z80 bus responder: detects memory/I/O cycles, maps 16-bit addresses
// through four page registers onto a 22-bit backing memory, drives WAIT.
module z80_bus_responder #(
   parameter logic [7:0] PAGE_IO_BASE = 8'h78,
   parameter int         MEM_TIMEOUT  = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_addr,
   input  logic        i_mreq_n,
   input  logic        i_iorq_n,
   input  logic        i_rd_n,
   input  logic        i_wr_n,
   input  logic        i_m1_n,
   input  logic        i_rfsh_n,
   input  logic [7:0]  i_data,
   output logic [7:0]  o_data,
   output logic        o_data_oe,
   output logic        o_wait_n,
   output logic [21:0] o_mem_addr,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [7:0]  o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [7:0]  i_mem_rdata,
   output logic        o_timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM,
      S_DONE
   } state_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_t      r_state;
   state_t      w_next;
   logic        r_prev_active;
   logic [7:0]  r_cnt;
   logic [7:0]  r_data;
   logic [7:0]  r_page [4];

   logic        w_rw;
   logic        w_mem_act;
   logic        w_io_act;
   logic        w_active;
   logic        w_start;
   logic        w_mem_start;
   logic        w_io_start;
   logic        w_tmo;
   logic        w_page_hit;
   logic [1:0]  w_pidx;

   assign w_rw        = !i_rd_n | !i_wr_n;
   assign w_mem_act   = !i_mreq_n & i_rfsh_n & w_rw;
   assign w_io_act    = !i_iorq_n & i_m1_n & w_rw;
   assign w_active    = w_mem_act | w_io_act;
   assign w_start     = w_active & !r_prev_active &
                        (r_state == S_IDLE) & !i_reset;
   assign w_mem_start = w_start & w_mem_act;
   assign w_io_start  = w_start & !w_mem_act;
   assign w_tmo       = (r_state == S_MEM) & !i_mem_ack &
                        (r_cnt >= TMO);
   assign w_page_hit  = i_addr[7:2] == PAGE_IO_BASE[7:2];
   assign w_pidx      = i_addr[1:0];
   assign o_data      = r_data;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state, WAIT and data-enable decode
   always_comb begin
      w_next    = r_state;
      o_wait_n  = 1'b1;
      o_data_oe = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_mem_start) begin
               w_next   = S_MEM;
               o_wait_n = 1'b0;
            end else if (w_io_start) begin
               w_next = S_DONE;
            end
         end
         S_MEM: begin
            if (i_mem_ack | w_tmo) w_next   = S_DONE;
            else                   o_wait_n = 1'b0;
         end
         S_DONE: begin
            o_data_oe = !i_rd_n;
            if (!w_active) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: edge detect, memory request, timeout, page registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prev_active <= 1'b1;
         r_cnt         <= 8'd0;
         r_data        <= 8'hFF;
         o_mem_req     <= 1'b0;
         o_mem_we      <= 1'b0;
         o_mem_addr    <= 22'd0;
         o_mem_wdata   <= 8'd0;
         o_timeout     <= 1'b0;
         for (int i = 0; i < 4; i++) r_page[i] <= 8'(i);
      end else begin
         r_prev_active <= w_active;
         o_timeout     <= 1'b0;
         if (w_mem_start) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= !i_wr_n;
            o_mem_addr  <= {r_page[i_addr[15:14]], i_addr[13:0]};
            o_mem_wdata <= i_data;
            r_cnt       <= 8'd1;
         end
         if (r_state == S_MEM) begin
            if (i_mem_ack) begin
               o_mem_req <= 1'b0;
               r_data    <= i_mem_rdata;
               r_cnt     <= 8'd0;
            end else if (w_tmo) begin
               o_mem_req <= 1'b0;
               r_data    <= 8'hFF;
               o_timeout <= 1'b1;
               r_cnt     <= 8'd0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
         if (w_io_start) begin
            if (!i_wr_n) begin
               r_data <= 8'hFF;
               if (w_page_hit) r_page[w_pidx] <= i_data;
            end else begin
               r_data <= w_page_hit ? r_page[w_pidx] : 8'hFF;
            end
         end
      end
   end

endmodule
